// File: rtl/ec_io_initiator_pkg.sv
// Shared definitions for the expansion-connector I/O bus: state encoding,
// device-select address map, front-panel addresses and default timing.
package ec_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } ec_state_t;

   // The four device selects cover 0x0000-0x03FF, one 256-byte block each.
   localparam logic [5:0]  IO_WINDOW_HI = 6'h00;
   localparam logic [15:0] SYSDEV_BASE  = 16'h0000;
   localparam logic [15:0] IODEV1_BASE  = 16'h0100;
   localparam logic [15:0] IODEV2_BASE  = 16'h0200;
   localparam logic [15:0] IODEV3_BASE  = 16'h0300;

   localparam logic [15:0] PFP_BASE     = 16'h0030;
   localparam logic [15:0] PFP_HALT     = 16'h0037;

   localparam int DEF_SETUP_CYCLES  = 1;
   localparam int DEF_STROBE_CYCLES = 2;
   localparam int DEF_WS_TIMEOUT    = 64;

   function automatic logic in_io_window(input logic [15:0] addr);
      return addr[15:10] == IO_WINDOW_HI;
   endfunction

endpackage

// File: rtl/ec_io_initiator_if.sv
// Core-side request/done handshake of the I/O initiator.
// master = processor core, slave = ec_io_initiator.
interface ec_io_initiator_if;
   logic        req;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_ready;
   logic        done;
   logic [15:0] rdata;
   logic        err;
   logic        halted;

   modport master (
      output req, req_we, req_addr, req_wdata,
      input  req_ready, done, rdata, err, halted
   );

   modport slave (
      input  req, req_we, req_addr, req_wdata,
      output req_ready, done, rdata, err, halted
   );
endinterface

// File: rtl/ec_io_initiator_decode.sv
// Combinational device-select decoder for the I/O window 0x0000-0x03FF.
// Shared with peripheral models, so it only depends on address and ec_nio.
module ec_io_decode
   import ec_bus_pkg::*;
(
   input  logic [15:0] addr,
   input  logic        nio,
   output logic        nsysdev,
   output logic        niodev1xx,
   output logic        niodev2xx,
   output logic        niodev3xx
);

   logic hit;

   assign hit       = !nio && in_io_window(addr);
   assign nsysdev   = !(hit && (addr[9:8] == SYSDEV_BASE[9:8]));
   assign niodev1xx = !(hit && (addr[9:8] == IODEV1_BASE[9:8]));
   assign niodev2xx = !(hit && (addr[9:8] == IODEV2_BASE[9:8]));
   assign niodev3xx = !(hit && (addr[9:8] == IODEV3_BASE[9:8]));

endmodule

// File: rtl/ec_io_initiator.sv
// Bus-master side of the expansion-connector I/O protocol.
// Optional wait-state timeout is enabled with `define EC_WS_TIMEOUT_EN.
module ec_io_initiator
   import ec_bus_pkg::*;
#(
   parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
   parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
   parameter int WS_TIMEOUT    = DEF_WS_TIMEOUT
) (
   input  logic               ec_clk,
   input  logic               ec_reset,
   ec_io_initiator_if.slave   core,
   output logic [15:0]        ec_ab,
   inout  wire  [15:0]        ec_db,
   output logic               ec_nio,
   output logic               ec_nr,
   output logic               ec_nw,
   output logic               ec_nsysdev,
   output logic               ec_niodev1xx,
   output logic               ec_niodev2xx,
   output logic               ec_niodev3xx,
   input  logic               ec_nws,
   input  logic               ec_nhalt
);

   localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
   localparam logic [15:0] STROBE_LEN = 16'(STROBE_CYCLES);

   ec_state_t   state;
   logic        we_q;
   logic [15:0] cnt;
   logic        sel_en;
   logic        db_oe;
   logic [15:0] db_out;
   logic        done_q;
   logic [15:0] rdata_q;
   logic        halted_q;
`ifdef EC_WS_TIMEOUT_EN
   localparam logic [15:0] WS_LAST = 16'(WS_TIMEOUT - 1);
   logic [15:0] strobe_cnt;
   logic [15:0] ws_cnt;
   logic        err_q;
`endif

   // Selects stay asserted through HOLD, so they follow sel_en rather than ec_nio.
   ec_io_decode u_decode (
      .addr      (ec_ab),
      .nio       (!sel_en),
      .nsysdev   (ec_nsysdev),
      .niodev1xx (ec_niodev1xx),
      .niodev2xx (ec_niodev2xx),
      .niodev3xx (ec_niodev3xx)
   );

   assign ec_db          = db_oe ? db_out : 16'hzzzz;
   assign core.req_ready = (state == ST_IDLE) && !halted_q;
   assign core.done      = done_q;
   assign core.rdata     = rdata_q;
   assign core.halted    = halted_q;
`ifdef EC_WS_TIMEOUT_EN
   assign core.err       = err_q;
`else
   assign core.err       = 1'b0;
`endif

   // Bus-cycle sequencer; every bus output is a register updated on the
   // same edge as the state it belongs to.
   always_ff @(posedge ec_clk) begin
      if (ec_reset) begin
         state    <= ST_IDLE;
         we_q     <= 1'b0;
         cnt      <= '0;
         sel_en   <= 1'b0;
         db_oe    <= 1'b0;
         db_out   <= '0;
         ec_ab    <= '0;
         ec_nio   <= 1'b1;
         ec_nr    <= 1'b1;
         ec_nw    <= 1'b1;
         done_q   <= 1'b0;
         rdata_q  <= '0;
         halted_q <= 1'b0;
`ifdef EC_WS_TIMEOUT_EN
         strobe_cnt <= '0;
         ws_cnt     <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         halted_q <= !ec_nhalt;
         done_q   <= 1'b0;
`ifdef EC_WS_TIMEOUT_EN
         err_q    <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (core.req && core.req_ready) begin
                  we_q   <= core.req_we;
                  ec_ab  <= core.req_addr;
                  db_out <= core.req_wdata;
                  db_oe  <= core.req_we;
                  ec_nio <= 1'b0;
                  sel_en <= 1'b1;
                  cnt    <= SETUP_LAST;
                  state  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt == '0) begin
                  cnt   <= STROBE_LEN;
                  ec_nr <= we_q;
                  ec_nw <= !we_q;
                  state <= ST_STROBE;
`ifdef EC_WS_TIMEOUT_EN
                  strobe_cnt <= '0;
                  ws_cnt     <= '0;
`endif
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            ST_STROBE: begin
               // Cycles with ec_nws low do not consume the strobe count.
               if (ec_nws && (cnt == 16'd1)) begin
                  ec_nr  <= 1'b1;
                  ec_nw  <= 1'b1;
                  ec_nio <= 1'b1;
                  done_q <= 1'b1;
                  if (!we_q) rdata_q <= ec_db;
                  state  <= ST_HOLD;
               end else if (ec_nws) begin
                  cnt <= cnt - 16'd1;
               end
`ifdef EC_WS_TIMEOUT_EN
               if (strobe_cnt != STROBE_LEN) strobe_cnt <= strobe_cnt + 16'd1;
               if (!ec_nws && (strobe_cnt == STROBE_LEN)) begin
                  if (ws_cnt == WS_LAST) begin
                     ec_nr  <= 1'b1;
                     ec_nw  <= 1'b1;
                     ec_nio <= 1'b1;
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                     if (!we_q) rdata_q <= 16'hFFFF;
                     state  <= ST_HOLD;
                  end else begin
                     ws_cnt <= ws_cnt + 16'd1;
                  end
               end else begin
                  ws_cnt <= '0;
               end
`endif
            end
            ST_HOLD: begin
               sel_en <= 1'b0;
               db_oe  <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ec_io_initiator.sv
// Directed testbench for ec_io_initiator: decode, strobe timing, wait states,
// halt, reset abort, back-to-back and (with EC_WS_TIMEOUT_EN) timeout.
module tb_ec_io_initiator;
   import ec_bus_pkg::*;

`ifdef EC_WS_TIMEOUT_EN
   localparam int TB_WS_TIMEOUT = 8;
`else
   localparam int TB_WS_TIMEOUT = DEF_WS_TIMEOUT;
`endif

   logic        ec_clk = 1'b0;
   logic        ec_reset;
   logic [15:0] ec_ab;
   wire  [15:0] ec_db;
   logic        ec_nio, ec_nr, ec_nw;
   logic        ec_nsysdev, ec_niodev1xx, ec_niodev2xx, ec_niodev3xx;
   logic        ec_nws;
   logic        ec_nhalt;
   logic        dev_en;
   logic [15:0] dev_data;

   int vectors     = 0;
   int miscompares = 0;

   ec_io_initiator_if core_if();

   ec_io_initiator #(
      .SETUP_CYCLES  (1),
      .STROBE_CYCLES (2),
      .WS_TIMEOUT    (TB_WS_TIMEOUT)
   ) dut (
      .ec_clk       (ec_clk),
      .ec_reset     (ec_reset),
      .core         (core_if.slave),
      .ec_ab        (ec_ab),
      .ec_db        (ec_db),
      .ec_nio       (ec_nio),
      .ec_nr        (ec_nr),
      .ec_nw        (ec_nw),
      .ec_nsysdev   (ec_nsysdev),
      .ec_niodev1xx (ec_niodev1xx),
      .ec_niodev2xx (ec_niodev2xx),
      .ec_niodev3xx (ec_niodev3xx),
      .ec_nws       (ec_nws),
      .ec_nhalt     (ec_nhalt)
   );

   always #5 ec_clk = ~ec_clk;

   // Bench peripheral drives read data only while ec_nr is low.
   assign ec_db = (dev_en && !ec_nr) ? dev_data : 16'hzzzz;

   task automatic apply_stimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      @(negedge ec_clk);
      core_if.req       = 1'b1;
      core_if.req_we    = we;
      core_if.req_addr  = addr;
      core_if.req_wdata = wdata;
   endtask

   // Follows one bus cycle cycle-by-cycle from the accept edge until done.
   task automatic observe(input int budget, input int ws_first, input int ws_last,
                          input bit pfp, input bit keep_req,
                          output int done_cyc, output int nr_low, output int nw_low,
                          output int nio_low, output logic [3:0] sel_seen,
                          output logic err_at_done, output logic [15:0] rdata_at_done,
                          output logic [15:0] db_at_done, output int oe_cycles);
      done_cyc = -1; nr_low = 0; nw_low = 0; nio_low = 0; sel_seen = 4'b0;
      err_at_done = 1'b0; rdata_at_done = 16'h0; db_at_done = 16'h0; oe_cycles = 0;
      for (int c = 1; c <= budget && done_cyc < 0; c++) begin
         @(negedge ec_clk);
         if (!keep_req) core_if.req = 1'b0;
         if (!ec_nr)  nr_low++;
         if (!ec_nw)  nw_low++;
         if (!ec_nio) nio_low++;
         if (dut.db_oe) oe_cycles++;
         sel_seen |= {!ec_niodev3xx, !ec_niodev2xx, !ec_niodev1xx, !ec_nsysdev};
         if (pfp && !ec_nw && ec_ab == PFP_HALT) ec_nhalt = 1'b0;
         if (core_if.done) begin
            done_cyc      = c;
            err_at_done   = core_if.err;
            rdata_at_done = core_if.rdata;
            db_at_done    = ec_db;
         end
         ec_nws = !(c >= ws_first && c <= ws_last);
      end
      ec_nws = 1'b1;
   endtask

   task automatic test_reset();
      ec_reset = 1'b1; core_if.req = 1'b0; core_if.req_we = 1'b0;
      core_if.req_addr = 16'h0; core_if.req_wdata = 16'h0;
      ec_nws = 1'b1; ec_nhalt = 1'b1; dev_en = 1'b0; dev_data = 16'h0;
      repeat (3) @(negedge ec_clk);
      vectors++;
      if ({ec_nio, ec_nr, ec_nw, ec_nsysdev, ec_niodev1xx, ec_niodev2xx, ec_niodev3xx} !== 7'h7F) begin
         miscompares++; $display("[TB] FAIL reset_strobes: got %b want 1111111",
            {ec_nio, ec_nr, ec_nw, ec_nsysdev, ec_niodev1xx, ec_niodev2xx, ec_niodev3xx});
      end
      vectors++;
      if ({ec_ab, core_if.rdata} !== 32'h0) begin
         miscompares++; $display("[TB] FAIL reset_ab_rdata: got %h want 00000000", {ec_ab, core_if.rdata});
      end
      vectors++;
      if ({core_if.done, core_if.err, core_if.halted, dut.db_oe} !== 4'b0000) begin
         miscompares++; $display("[TB] FAIL reset_flags: got %b want 0000",
            {core_if.done, core_if.err, core_if.halted, dut.db_oe});
      end
      ec_reset = 1'b0;
      @(negedge ec_clk);
      vectors++;
      if (core_if.req_ready !== 1'b1) begin
         miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", core_if.req_ready);
      end
   endtask

   task automatic test_read_decode(input logic [15:0] addr, input logic [15:0] data,
                                   input logic [3:0] exp_sel, input string name);
      int d, nr, nw, nio, oe; logic [3:0] sel; logic e; logic [15:0] rd, db;
      dev_en = 1'b1; dev_data = data;
      apply_stimulus(1'b0, addr, 16'h0);
      observe(20, 0, 0, 1'b0, 1'b0, d, nr, nw, nio, sel, e, rd, db, oe);
      vectors++;
      if (d !== 4 || e !== 1'b0) begin
         miscompares++; $display("[TB] FAIL %s_done: got cycle %0d err %b want cycle 4 err 0", name, d, e);
      end
      vectors++;
      if (rd !== data) begin
         miscompares++; $display("[TB] FAIL %s_rdata: got %h want %h", name, rd, data);
      end
      vectors++;
      if (sel !== exp_sel || nio !== 3 || nr !== 2 || nw !== 0) begin
         miscompares++; $display("[TB] FAIL %s_bus: got sel %b nio %0d nr %0d nw %0d want sel %b nio 3 nr 2 nw 0",
            name, sel, nio, nr, nw, exp_sel);
      end
      vectors++;
      if (oe !== 0) begin
         miscompares++; $display("[TB] FAIL %s_db_drive: got %0d driven cycles want 0", name, oe);
      end
      dev_data = 16'h0;
      @(negedge ec_clk);
      vectors++;
      if ({core_if.done, ec_nsysdev, ec_niodev1xx, ec_niodev2xx, ec_niodev3xx} !== 5'b01111 || core_if.rdata !== data) begin
         miscompares++; $display("[TB] FAIL %s_after: got done/sel %b rdata %h want 01111 rdata %h",
            name, {core_if.done, ec_nsysdev, ec_niodev1xx, ec_niodev2xx, ec_niodev3xx}, core_if.rdata, data);
      end
      dev_en = 1'b0;
   endtask

   task automatic test_wait_states();
      int d, nr, nw, nio, oe; logic [3:0] sel; logic e; logic [15:0] rd, db;
      dev_en = 1'b1; dev_data = 16'hC3A5;
      apply_stimulus(1'b0, 16'h0201, 16'h0);
      observe(30, 2, 4, 1'b0, 1'b0, d, nr, nw, nio, sel, e, rd, db, oe);
      vectors++;
      if (d !== 7 || nr !== 5) begin
         miscompares++; $display("[TB] FAIL ws_timing: got done cycle %0d nr low %0d want 7 and 5", d, nr);
      end
      vectors++;
      if (rd !== 16'hC3A5 || sel !== 4'b0100) begin
         miscompares++; $display("[TB] FAIL ws_data_sel: got rdata %h sel %b want c3a5 0100", rd, sel);
      end
      dev_en = 1'b0;
   endtask

   task automatic test_halt_write();
      int d, nr, nw, nio, oe, busy; logic [3:0] sel; logic e; logic [15:0] rd, db;
      apply_stimulus(1'b1, PFP_HALT, 16'h1234);
      observe(20, 0, 0, 1'b1, 1'b0, d, nr, nw, nio, sel, e, rd, db, oe);
      vectors++;
      if (d !== 4 || nw !== 2 || nr !== 0 || sel !== 4'b0001) begin
         miscompares++; $display("[TB] FAIL pfp_write: got done %0d nw %0d nr %0d sel %b want 4 2 0 0001", d, nw, nr, sel);
      end
      vectors++;
      if (db !== 16'h1234 || oe !== 4) begin
         miscompares++; $display("[TB] FAIL pfp_db: got db %h oe cycles %0d want 1234 4", db, oe);
      end
      @(negedge ec_clk);
      vectors++;
      if ({core_if.halted, core_if.req_ready, dut.db_oe} !== 3'b100) begin
         miscompares++; $display("[TB] FAIL halt_state: got halted/ready/oe %b want 100",
            {core_if.halted, core_if.req_ready, dut.db_oe});
      end
      core_if.req = 1'b1; core_if.req_we = 1'b0; core_if.req_addr = 16'h0150;
      busy = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge ec_clk);
         if (!ec_nio || core_if.done) busy++;
      end
      vectors++;
      if (busy !== 0) begin
         miscompares++; $display("[TB] FAIL halt_ignore: got %0d active cycles want 0", busy);
      end
      ec_nhalt = 1'b1;
      @(negedge ec_clk);
      core_if.req = 1'b0;
      vectors++;
      if ({core_if.halted, core_if.req_ready, ec_nio} !== 3'b011) begin
         miscompares++; $display("[TB] FAIL halt_release: got halted/ready/nio %b want 011",
            {core_if.halted, core_if.req_ready, ec_nio});
      end
   endtask

   task automatic test_reset_abort();
      int dones;
      apply_stimulus(1'b1, 16'h0300, 16'hA5A5);
      @(negedge ec_clk); core_if.req = 1'b0;
      @(negedge ec_clk);
      @(negedge ec_clk);
      vectors++;
      if (ec_nw !== 1'b0 || ec_niodev3xx !== 1'b0) begin
         miscompares++; $display("[TB] FAIL abort_precond: got nw %b niodev3xx %b want 0 0", ec_nw, ec_niodev3xx);
      end
      ec_reset = 1'b1;
      @(negedge ec_clk);
      ec_reset = 1'b0;
      vectors++;
      if ({ec_nio, ec_nr, ec_nw, ec_niodev3xx, dut.db_oe, core_if.done, core_if.req_ready} !== 7'b1111001) begin
         miscompares++; $display("[TB] FAIL abort_state: got %b want 1111001",
            {ec_nio, ec_nr, ec_nw, ec_niodev3xx, dut.db_oe, core_if.done, core_if.req_ready});
      end
      dones = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge ec_clk);
         if (core_if.done) dones++;
      end
      vectors++;
      if (dones !== 0) begin
         miscompares++; $display("[TB] FAIL abort_no_done: got %0d dones want 0", dones);
      end
   endtask

   task automatic test_back_to_back();
      int d1, d2, nr, nw, nio, oe; logic [3:0] sel; logic e; logic [15:0] rd, db;
      dev_en = 1'b1; dev_data = 16'h7E57;
      apply_stimulus(1'b0, 16'h0110, 16'h0);
      observe(20, 0, 0, 1'b0, 1'b1, d1, nr, nw, nio, sel, e, rd, db, oe);
      observe(20, 0, 0, 1'b0, 1'b1, d2, nr, nw, nio, sel, e, rd, db, oe);
      core_if.req = 1'b0;
      vectors++;
      if (d1 !== 4 || d2 !== 5) begin
         miscompares++; $display("[TB] FAIL b2b_spacing: got %0d then %0d want 4 then 5", d1, d2);
      end
      @(negedge ec_clk);
      @(negedge ec_clk);
      vectors++;
      if (ec_nio !== 1'b1 || core_if.req_ready !== 1'b1) begin
         miscompares++; $display("[TB] FAIL b2b_idle: got nio %b ready %b want 1 1", ec_nio, core_if.req_ready);
      end
      dev_en = 1'b0;
   endtask

`ifdef EC_WS_TIMEOUT_EN
   task automatic test_ws_timeout();
      int d, nr, nw, nio, oe; logic [3:0] sel; logic e; logic [15:0] rd, db;
      dev_en = 1'b1; dev_data = 16'h1111;
      apply_stimulus(1'b0, 16'h0150, 16'h0);
      observe(40, 1, 1000, 1'b0, 1'b0, d, nr, nw, nio, sel, e, rd, db, oe);
      vectors++;
      if (d !== 12 || e !== 1'b1 || nr !== 10) begin
         miscompares++; $display("[TB] FAIL ws_timeout: got done %0d err %b nr %0d want 12 1 10", d, e, nr);
      end
      vectors++;
      if (rd !== 16'hFFFF) begin
         miscompares++; $display("[TB] FAIL ws_timeout_rdata: got %h want ffff", rd);
      end
      dev_en = 1'b0;
      @(negedge ec_clk);
   endtask
`endif

   initial begin
      test_reset();
      test_halt_write();
      test_read_decode(16'h0150, 16'hBEEF, 4'b0010, "read_iodev1");
      test_read_decode(16'h1000, 16'h0F0F, 4'b0000, "read_nodev");
      test_wait_states();
      test_reset_abort();
      test_back_to_back();
`ifdef EC_WS_TIMEOUT_EN
      test_ws_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no completion want $finish before 100000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
